// File: rtl/sop_lut_seq_pkg.sv
// Shared types and sizing helpers for the programmable sum-of-products evaluator.
package sop_lut_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam int DEFAULT_N_IN = 4;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

    // Popcount of a 2**n table needs one extra bit to hold the all-ones total.
    function automatic int count_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/sop_lut_core.sv
// Committed truth table plus registered one-cycle evaluation port.
module sop_lut_core
    import sop_lut_seq_pkg::*;
#(
    parameter int               N_IN       = DEFAULT_N_IN,
    parameter int               DEPTH      = 16,
    parameter logic [DEPTH-1:0] INIT_TABLE = 16'h88E6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [DEPTH-1:0] new_table,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic             s,
    output logic [DEPTH-1:0] lut
);

    // Table commit and lookup share the edge, so a lookup in the commit cycle sees the old table.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut       <= INIT_TABLE;
            out_valid <= 1'b0;
            s         <= 1'b0;
        end else begin
            if (commit) begin
                lut <= new_table;
            end
            out_valid <= in_valid;
            if (in_valid) begin
                s <= lut[in_vec];
            end
        end
    end

endmodule

// File: rtl/sop_lut_seq.sv
// Programmable function generator: serial table load, registered evaluation and table sweep.
module sop_lut_seq
    import sop_lut_seq_pkg::*;
#(
    parameter int                   N_IN       = DEFAULT_N_IN,
    parameter logic [2**N_IN-1:0]   INIT_TABLE = 16'h88E6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_start,
    input  logic            ld_valid,
    input  logic            ld_bit,
    output logic            ld_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    output logic            s,
    input  logic            sweep_start,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_s,
    output logic            sweep_done,
    output logic [N_IN:0]   ones_count,
    output logic            busy
);

    localparam int DEPTH = depth_of(N_IN);
    localparam int CNT_W = count_width(N_IN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   idx;
    logic [N_IN-1:0]    idx_lo;
    logic               last_idx;
    logic [DEPTH-1:0]   shadow;
    logic [DEPTH-1:0]   next_shadow;
    logic [DEPTH-1:0]   lut;
    logic               load_commit;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W-1:0]   ones_reg;

    assign idx_lo   = idx[N_IN-1:0];
    assign last_idx = (idx == LAST);

    sop_lut_core #(
        .N_IN       (N_IN),
        .DEPTH      (DEPTH),
        .INIT_TABLE (INIT_TABLE)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .commit    (load_commit),
        .new_table (next_shadow),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .s         (s),
        .lut       (lut)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; ld_start has priority over sweep_start in IDLE.
    always_comb begin
        next_state          = state;
        load_commit         = 1'b0;
        next_shadow         = shadow;
        next_shadow[idx_lo] = ld_bit;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    next_state = LOAD;
                end else if (sweep_start) begin
                    next_state = SWEEP;
                end else begin
                    next_state = IDLE;
                end
            end
            LOAD: begin
                if (ld_valid && last_idx) begin
                    next_state  = IDLE;
                    load_commit = 1'b1;
                end else begin
                    next_state = LOAD;
                end
            end
            SWEEP: begin
                if (last_idx) begin
                    next_state = IDLE;
                end else begin
                    next_state = SWEEP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign sweep_valid = (state == SWEEP);
    assign sweep_idx   = (state == SWEEP) ? idx_lo : '0;
    assign sweep_s     = (state == SWEEP) ? lut[idx_lo] : 1'b0;
    assign sweep_done  = (state == SWEEP) && last_idx;
    // The final sweep cycle already shows the full total, before it is latched.
    assign ones_count  = sweep_done ? (acc + CNT_W'(sweep_s)) : ones_reg;

    // Index counter, shadow table, sweep accumulator and load-done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            shadow   <= '0;
            acc      <= '0;
            ones_reg <= '0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= load_commit;
            case (state)
                IDLE: begin
                    idx <= '0;
                    acc <= '0;
                end
                LOAD: begin
                    if (ld_valid) begin
                        shadow <= next_shadow;
                        idx    <= last_idx ? '0 : idx + CNT_W'(1);
                    end
                end
                SWEEP: begin
                    acc <= acc + CNT_W'(sweep_s);
                    idx <= last_idx ? '0 : idx + CNT_W'(1);
                    if (last_idx) begin
                        ones_reg <= ones_count;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sop_lut_seq.sv
// Directed bench for sop_lut_seq: scoreboard for evaluation, direct checks for load and sweep.
module tb_sop_lut_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ld_start, ld_valid, ld_bit, in_valid, sweep_start;
    logic [3:0] in_vec;
    logic       ld_done, out_valid, s, sweep_valid, sweep_s, sweep_done, busy;
    logic [3:0] sweep_idx;
    logic [4:0] ones_count;

    logic       ld_start3, ld_valid3, ld_bit3, in_valid3, sweep_start3;
    logic [2:0] in_vec3;
    logic       ld_done3, out_valid3, s3, sweep_valid3, sweep_s3, sweep_done3, busy3;
    logic [2:0] sweep_idx3;
    logic [3:0] ones_count3;

    int          checks = 0;
    int          errors = 0;
    logic        sb[$];
    logic [15:0] model;
    logic [7:0]  model3;

    sop_lut_seq #(.N_IN(4), .INIT_TABLE(16'h88E6)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_bit(ld_bit),
        .ld_done(ld_done), .in_valid(in_valid), .in_vec(in_vec), .out_valid(out_valid),
        .s(s), .sweep_start(sweep_start), .sweep_valid(sweep_valid), .sweep_idx(sweep_idx),
        .sweep_s(sweep_s), .sweep_done(sweep_done), .ones_count(ones_count), .busy(busy)
    );

    sop_lut_seq #(.N_IN(3), .INIT_TABLE(8'h66)) dut3 (
        .clk(clk), .rst(rst), .ld_start(ld_start3), .ld_valid(ld_valid3), .ld_bit(ld_bit3),
        .ld_done(ld_done3), .in_valid(in_valid3), .in_vec(in_vec3), .out_valid(out_valid3),
        .s(s3), .sweep_start(sweep_start3), .sweep_valid(sweep_valid3), .sweep_idx(sweep_idx3),
        .sweep_s(sweep_s3), .sweep_done(sweep_done3), .ones_count(ones_count3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the evaluation port is scored against the queue every cycle.
    task automatic tick();
        logic drove;
        logic exp_s;
        drove = in_valid;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, drove);
        if (drove) begin
            exp_s = sb.pop_front();
            chk("s", s, exp_s);
        end
    endtask

    task automatic eval(input logic [3:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        sb.push_back(model[v]);
        tick();
        in_valid = 1'b0;
    endtask

    // Assumes LOAD already accepted; the last bit is paired with an evaluation on the old table.
    task automatic load_body(input logic [15:0] val);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("ld_done_gap", ld_done, 1'b0);
            end
            ld_valid = 1'b1;
            ld_bit   = val[i];
            if (i == 15) begin
                in_valid = 1'b1;
                in_vec   = 4'b1001;
                sb.push_back(model[4'b1001]);
            end
            tick();
            ld_valid = 1'b0;
            in_valid = 1'b0;
            chk("ld_done", ld_done, (i == 15));
            chk("busy_load", busy, (i != 15));
        end
        model = val;
        tick();
        chk("ld_done_pulse", ld_done, 1'b0);
    endtask

    task automatic sweep16();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("sweep_valid", sweep_valid, 1'b1);
            chk("sweep_idx", sweep_idx, i);
            chk("sweep_s", sweep_s, model[i]);
            chk("sweep_done", sweep_done, (i == 15));
            chk("busy_sweep", busy, 1'b1);
            if (i == 15) chk("ones_final", ones_count, $countones(model));
            tick();
        end
        chk("sweep_valid_end", sweep_valid, 1'b0);
        chk("sweep_done_end", sweep_done, 1'b0);
        chk("busy_end", busy, 1'b0);
        chk("ones_hold", ones_count, $countones(model));
    endtask

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_bit = 1'b0;
        in_valid = 1'b0; in_vec = 4'd0; sweep_start = 1'b0;
        ld_start3 = 1'b0; ld_valid3 = 1'b0; ld_bit3 = 1'b0;
        in_valid3 = 1'b0; in_vec3 = 3'd0; sweep_start3 = 1'b0;
        model  = 16'h88E6;
        model3 = 8'h66;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ld_done", ld_done, 1'b0);
        chk("rst_s", s, 1'b0);
        chk("rst_sweep_valid", sweep_valid, 1'b0);
        chk("rst_sweep_idx", sweep_idx, 4'd0);
        chk("rst_sweep_s", sweep_s, 1'b0);
        chk("rst_sweep_done", sweep_done, 1'b0);
        chk("rst_ones", ones_count, 5'd0);
        chk("rst_busy", busy, 1'b0);

        // Default-table evaluation, then s holds while in_valid is low.
        eval(4'b0111);
        eval(4'b0000);
        eval(4'b1011);
        tick();
        chk("s_hold", s, 1'b1);

        sweep16();

        // Simultaneous starts: load wins, sweep requests inside LOAD are ignored.
        ld_start = 1'b1;
        sweep_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("dual_busy", busy, 1'b1);
        chk("dual_no_sweep", sweep_valid, 1'b0);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        chk("load_ignore_sweep", sweep_valid, 1'b0);
        eval(4'b0111);
        eval(4'b1000);
        load_body(16'h0A43);
        eval(4'b1001);
        eval(4'b0010);
        sweep16();

        // All-ones table exercises the widest ones_count.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        load_body(16'hFFFF);
        sweep16();

        // Reset mid-load discards the partial table.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ld_valid = 1'b1;
            ld_bit   = 1'b0;
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model = 16'h88E6;
        chk("rst_load_busy", busy, 1'b0);
        chk("rst_load_done", ld_done, 1'b0);
        chk("rst_load_ones", ones_count, 5'd0);
        tick();
        chk("rst_load_done2", ld_done, 1'b0);
        eval(4'b0111);
        eval(4'b0110);
        eval(4'b0100);

        // Reset mid-sweep aborts without sweep_done.
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_idx", sweep_idx, i);
            if (i < 5) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_done", sweep_done, 1'b0);
        chk("abort_valid", sweep_valid, 1'b0);
        chk("abort_ones", ones_count, 5'd0);
        chk("abort_busy", busy, 1'b0);
        tick();
        chk("abort_done2", sweep_done, 1'b0);

        // Three-input instance.
        in_valid3 = 1'b1;
        in_vec3 = 3'b001;
        tick();
        chk("n3_ov", out_valid3, 1'b1);
        chk("n3_s001", s3, model3[1]);
        in_vec3 = 3'b110;
        tick();
        chk("n3_s110", s3, model3[6]);
        in_vec3 = 3'b000;
        tick();
        chk("n3_s000", s3, model3[0]);
        in_valid3 = 1'b0;
        sweep_start3 = 1'b1;
        tick();
        sweep_start3 = 1'b0;
        chk("n3_ov_low", out_valid3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("n3_sweep_valid", sweep_valid3, 1'b1);
            chk("n3_sweep_idx", sweep_idx3, i);
            chk("n3_sweep_s", sweep_s3, model3[i]);
            chk("n3_sweep_done", sweep_done3, (i == 7));
            if (i == 7) chk("n3_ones", ones_count3, $countones(model3));
            tick();
        end
        chk("n3_sweep_end", sweep_valid3, 1'b0);
        chk("n3_busy_end", busy3, 1'b0);
        chk("n3_ones_hold", ones_count3, 4'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
